// File: rtl/gpu_rect_fill_if.sv
// Framebuffer write port of the rectangle-fill engine.
// Handshake: FB_WE is valid, FB_READY is ready; a pixel transfers on a rising edge
// where both are high, and FB_ADDR/FB_DATA/FB_WE hold steady until that edge.
interface gpu_rect_fill_if;
  logic [12:0] FB_ADDR;
  logic [6:0]  FB_DATA;
  logic        FB_WE;
  logic        FB_READY;

  modport master (output FB_ADDR, output FB_DATA, output FB_WE, input FB_READY);
  modport slave  (input FB_ADDR, input FB_DATA, input FB_WE, output FB_READY);
endinterface

// File: rtl/gpu_rect_fill.sv
// Rectangle-fill engine: CPU-programmed register file, clipping, and a row-major
// pixel stream into the framebuffer write port.
module gpu_rect_fill #(
  parameter int FB_W = 80,
  parameter int FB_H = 60
) (
  input  logic        CLK_SYS,
  input  logic        RESET_N,
  input  logic        CE,
  input  logic        RW,
  input  logic [2:0]  ADDR,
  input  logic [7:0]  DATA,
  output logic [7:0]  DATA_OUT,
  output logic        DATA_OE,
  output logic        BUSY,
  output logic [1:0]  dbg_state_o,
  gpu_rect_fill_if.master fb
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_FILL  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [7:0]  FB_W8  = 8'(FB_W);
  localparam logic [7:0]  FB_H8  = 8'(FB_H);
  localparam logic [12:0] FB_W13 = 13'(FB_W);

  logic       ce_s1_q, ce_s2_q, rw_s1_q, rw_s2_q, ev_seen_q;
  logic [2:0] addr_s1_q, addr_s2_q;
  logic [7:0] data_s1_q, data_s2_q;

  logic [6:0] x_q, w_q;
  logic [5:0] y_q, h_q;
  logic [2:0] color_q;
  logic       swp_q;

  logic [1:0]  state_q;
  logic        done_q, err_q, we_q;
  logic [12:0] addr_q, row_base_q;
  logic [6:0]  data_q;
  logic [6:0]  w_eff_q, col_q;
  logic [5:0]  h_eff_q, row_q;
  logic [2:0]  lat_color_q;
  logic        lat_swp_q;

  logic busy, wr_ev, cmd_wr;
  assign busy   = (state_q == S_SETUP) || (state_q == S_FILL);
  assign wr_ev  = ~ce_s2_q & ~rw_s2_q & ~ev_seen_q;
  assign cmd_wr = wr_ev & ~busy & (addr_s2_q == 3'd5);

  // Two-flop synchroniser; CE/RW idle high so reset cannot fake a write event.
  always_ff @(posedge CLK_SYS or negedge RESET_N) begin
    if (!RESET_N) begin
      ce_s1_q   <= 1'b1;
      ce_s2_q   <= 1'b1;
      rw_s1_q   <= 1'b1;
      rw_s2_q   <= 1'b1;
      addr_s1_q <= '0;
      addr_s2_q <= '0;
      data_s1_q <= '0;
      data_s2_q <= '0;
      ev_seen_q <= 1'b0;
    end else begin
      ce_s1_q   <= CE;
      ce_s2_q   <= ce_s1_q;
      rw_s1_q   <= RW;
      rw_s2_q   <= rw_s1_q;
      addr_s1_q <= ADDR;
      addr_s2_q <= addr_s1_q;
      data_s1_q <= DATA;
      data_s2_q <= data_s1_q;
      ev_seen_q <= ce_s2_q ? 1'b0 : (ev_seen_q | wr_ev);
    end
  end

  always_ff @(posedge CLK_SYS or negedge RESET_N) begin
    if (!RESET_N) begin
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      color_q <= '0;
      swp_q   <= 1'b0;
    end else if (wr_ev && !busy) begin
      case (addr_s2_q)
        3'd0: x_q <= data_s2_q[6:0];
        3'd1: y_q <= data_s2_q[5:0];
        3'd2: w_q <= data_s2_q[6:0];
        3'd3: h_q <= data_s2_q[5:0];
        3'd4: begin
          color_q <= data_s2_q[2:0];
          swp_q   <= data_s2_q[6];
        end
        default: ;
      endcase
    end
  end

  // Clipping against the framebuffer edge, evaluated during SETUP.
  logic [7:0]  rem_w, rem_h, w_min8, h_min8;
  logic [6:0]  w_eff_d;
  logic [5:0]  h_eff_d;
  logic        degen, first_last;
  logic [12:0] row_base_init;
  assign rem_w         = FB_W8 - {1'b0, x_q};
  assign rem_h         = FB_H8 - {2'b00, y_q};
  assign w_min8        = ({1'b0, w_q} < rem_w) ? {1'b0, w_q} : rem_w;
  assign h_min8        = ({2'b00, h_q} < rem_h) ? {2'b00, h_q} : rem_h;
  assign w_eff_d       = w_min8[6:0];
  assign h_eff_d       = h_min8[5:0];
  assign degen         = (w_q == '0) || (h_q == '0) || ({1'b0, x_q} >= FB_W8) || ({2'b00, y_q} >= FB_H8);
  assign first_last    = (w_eff_d == 7'd1) && (h_eff_d == 6'd1);
  assign row_base_init = 13'(y_q) * FB_W13 + 13'(x_q);

  logic        at_row_end, last, n_last;
  logic [6:0]  n_col;
  logic [5:0]  n_row;
  logic [12:0] n_base;
  assign at_row_end = (col_q == w_eff_q - 7'd1);
  assign last       = at_row_end && (row_q == h_eff_q - 6'd1);
  assign n_col      = at_row_end ? 7'd0 : col_q + 7'd1;
  assign n_row      = at_row_end ? row_q + 6'd1 : row_q;
  assign n_base     = at_row_end ? row_base_q + FB_W13 : row_base_q;
  assign n_last     = (n_col == w_eff_q - 7'd1) && (n_row == h_eff_q - 6'd1);

  always_ff @(posedge CLK_SYS or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      row_base_q  <= '0;
      w_eff_q     <= '0;
      h_eff_q     <= '0;
      col_q       <= '0;
      row_q       <= '0;
      lat_color_q <= '0;
      lat_swp_q   <= 1'b0;
    end else begin
      if (wr_ev && busy) err_q <= 1'b1;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (state_q == S_DONE) done_q <= 1'b1;
          state_q <= S_IDLE;
          if (cmd_wr) begin
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (degen) begin
            state_q <= S_DONE;
          end else begin
            w_eff_q     <= w_eff_d;
            h_eff_q     <= h_eff_d;
            lat_color_q <= color_q;
            lat_swp_q   <= swp_q;
            row_base_q  <= row_base_init;
            col_q       <= '0;
            row_q       <= '0;
            addr_q      <= row_base_init;
            data_q      <= {swp_q & first_last, 3'b000, color_q};
            we_q        <= 1'b1;
            state_q     <= S_FILL;
          end
        end
        default: begin
          if (fb.FB_READY) begin
            if (last) begin
              we_q    <= 1'b0;
              state_q <= S_DONE;
            end else begin
              col_q      <= n_col;
              row_q      <= n_row;
              row_base_q <= n_base;
              addr_q     <= n_base + 13'(n_col);
              data_q     <= {lat_swp_q & n_last, 3'b000, lat_color_q};
            end
          end
        end
      endcase
    end
  end

  logic [3:0] unused_bits;
  assign unused_bits = {data_s2_q[7], w_min8[7], h_min8[7:6]};

  assign fb.FB_WE    = we_q;
  assign fb.FB_ADDR  = addr_q;
  assign fb.FB_DATA  = data_q;
  assign BUSY        = busy;
  assign dbg_state_o = state_q;
  assign DATA_OE     = ~CE & RW;
  assign DATA_OUT    = DATA_OE ? {busy, err_q, 5'b00000, done_q} : 8'h00;

endmodule

// File: tb/tb_gpu_rect_fill.sv
// Self-checking bench for gpu_rect_fill: vector table of fills plus hand-written
// sequences for write-while-busy and reset in the middle of a fill.
module tb_gpu_rect_fill;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce = 1'b1;
  logic       rw = 1'b1;
  logic [2:0] addr = '0;
  logic [7:0] data = '0;
  logic [7:0] data_out;
  logic       data_oe, busy;
  logic [1:0] dbg_state;

  gpu_rect_fill_if fb_if ();

  gpu_rect_fill dut (
    .CLK_SYS    (clk),
    .RESET_N    (rst_n),
    .CE         (ce),
    .RW         (rw),
    .ADDR       (addr),
    .DATA       (data),
    .DATA_OUT   (data_out),
    .DATA_OE    (data_oe),
    .BUSY       (busy),
    .dbg_state_o(dbg_state),
    .fb         (fb_if.master)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_acc = 0;
  int busy_cycles = 0;
  int rdy_mode = 0;
  logic [19:0] exp_q[$];
  logic [19:0] held;
  logic        hold_valid = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // FB_READY driver: mode 0 always ready, mode 1 repeats 1-0-0.
  initial begin
    int ph = 0;
    fb_if.FB_READY = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 1) begin
        fb_if.FB_READY = (ph == 0);
        ph = (ph + 1) % 3;
      end else begin
        fb_if.FB_READY = 1'b1;
        ph = 0;
      end
    end
  end

  // Scoreboard: every accepted pixel is popped against the expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busy_cycles++;
      if (hold_valid)
        check("hold_stable", {11'd0, fb_if.FB_WE, fb_if.FB_ADDR, fb_if.FB_DATA}, {11'd0, 1'b1, held});
      hold_valid = 1'b0;
      if (fb_if.FB_WE && fb_if.FB_READY) begin
        n_acc++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_write: addr %0d data 0x%0h, expected none", fb_if.FB_ADDR, fb_if.FB_DATA);
        end else begin
          check("fb_write", {12'd0, fb_if.FB_ADDR, fb_if.FB_DATA}, {12'd0, exp_q.pop_front()});
        end
      end else if (fb_if.FB_WE) begin
        held       = {fb_if.FB_ADDR, fb_if.FB_DATA};
        hold_valid = 1'b1;
      end
    end
  end

  task automatic cpu_write(input logic [2:0] a, input logic [7:0] d);
    @(posedge clk);
    #1;
    ce = 1'b0; rw = 1'b0; addr = a; data = d;
    repeat (4) @(posedge clk);
    #1;
    ce = 1'b1; rw = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic check_status(input string nm, input logic [7:0] exp);
    @(negedge clk);
    ce = 1'b0; rw = 1'b1; addr = 3'($urandom_range(0, 7));
    #1;
    check({nm, "_oe"}, {31'd0, data_oe}, 32'd1);
    check(nm, {24'd0, data_out}, {24'd0, exp});
    ce = 1'b1;
    #1;
    check({nm, "_oe_off"}, {31'd0, data_oe}, 32'd0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while ((busy || dbg_state != 2'd0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      n_vec++;
      n_err++;
      $display("FAIL idle_timeout: still busy after %0d cycles, expected idle", n);
    end
  endtask

  task automatic wait_acc(input int target, input int budget);
    int n = 0;
    while (n_acc < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      n_vec++;
      n_err++;
      $display("FAIL acc_timeout: %0d pixels accepted, expected %0d", n_acc, target);
    end
  endtask

  typedef struct {
    logic [7:0]  x, y, w, h, color;
    int          mode;
    int          n;
    int          exp_busy;
    logic [12:0] ea[10];
    logic [6:0]  ed[10];
  } vec_t;

  function automatic vec_t mk(input int x, y, w, h, c, m, n, b);
    vec_t v;
    v.x = 8'(x); v.y = 8'(y); v.w = 8'(w); v.h = 8'(h); v.color = 8'(c);
    v.mode = m; v.n = n; v.exp_busy = b;
    for (int i = 0; i < 10; i++) begin
      v.ea[i] = '0;
      v.ed[i] = '0;
    end
    return v;
  endfunction

  vec_t vt[8];

  initial begin
    vt[0] = mk(2, 3, 4, 2, 8'h05, 0, 8, 9);
    vt[0].ea = '{13'd242, 13'd243, 13'd244, 13'd245, 13'd322, 13'd323, 13'd324, 13'd325, 13'd0, 13'd0};
    vt[0].ed = '{7'h05, 7'h05, 7'h05, 7'h05, 7'h05, 7'h05, 7'h05, 7'h05, 7'h00, 7'h00};
    vt[1] = mk(78, 59, 10, 10, 8'h43, 0, 2, 3);
    vt[1].ea = '{13'd4798, 13'd4799, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0};
    vt[1].ed = '{7'h03, 7'h43, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    vt[2] = mk(2, 3, 4, 2, 8'h05, 1, 8, -1);
    vt[2].ea = vt[0].ea;
    vt[2].ed = vt[0].ed;
    vt[3] = mk(5, 5, 0, 4, 8'h07, 0, 0, 1);
    vt[4] = mk(80, 5, 4, 4, 8'h07, 0, 0, 1);
    vt[5] = mk(0, 0, 1, 1, 8'h47, 0, 1, 2);
    vt[5].ea[0] = 13'd0;
    vt[5].ed[0] = 7'h47;
    vt[6] = mk(79, 0, 5, 3, 8'h02, 0, 3, 4);
    vt[6].ea = '{13'd79, 13'd159, 13'd239, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0};
    vt[6].ed = '{7'h02, 7'h02, 7'h02, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    vt[7] = mk(70, 10, 127, 1, 8'h41, 0, 10, 11);
    vt[7].ea = '{13'd870, 13'd871, 13'd872, 13'd873, 13'd874, 13'd875, 13'd876, 13'd877, 13'd878, 13'd879};
    vt[7].ed = '{7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h41};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_we", {31'd0, fb_if.FB_WE}, 32'd0);
    check("rst_addr", {19'd0, fb_if.FB_ADDR}, 32'd0);
    check("rst_data", {25'd0, fb_if.FB_DATA}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_oe", {31'd0, data_oe}, 32'd0);
    check_status("rst_status", 8'h00);

    for (int i = 0; i < 8; i++) begin
      rdy_mode = vt[i].mode;
      for (int k = 0; k < vt[i].n; k++) exp_q.push_back({vt[i].ea[k], vt[i].ed[k]});
      cpu_write(3'd0, vt[i].x);
      cpu_write(3'd1, vt[i].y);
      cpu_write(3'd2, vt[i].w);
      cpu_write(3'd3, vt[i].h);
      cpu_write(3'd4, vt[i].color);
      busy_cycles = 0;
      n_acc = 0;
      cpu_write(3'd5, 8'h00);
      wait_idle(200);
      check($sformatf("v%0d_count", i), n_acc, vt[i].n);
      check($sformatf("v%0d_left", i), exp_q.size(), 0);
      if (vt[i].exp_busy >= 0) check($sformatf("v%0d_busy", i), busy_cycles, vt[i].exp_busy);
      check_status($sformatf("v%0d_status", i), 8'h01);
      exp_q.delete();
    end
    rdy_mode = 0;

    // Full-screen fill with a COLOR write landing mid-fill.
    for (int i = 0; i < 4800; i++) exp_q.push_back({13'(i), 7'h01});
    cpu_write(3'd0, 8'd0);
    cpu_write(3'd1, 8'd0);
    cpu_write(3'd2, 8'd80);
    cpu_write(3'd3, 8'd60);
    cpu_write(3'd4, 8'h01);
    n_acc = 0;
    busy_cycles = 0;
    cpu_write(3'd5, 8'h00);
    wait_acc(200, 400);
    cpu_write(3'd4, 8'h06);
    check_status("busy_err_status", 8'hC0);
    wait_idle(6000);
    check("full_count", n_acc, 4800);
    check("full_busy", busy_cycles, 4801);
    check("full_left", exp_q.size(), 0);
    check_status("after_err_status", 8'h41);
    cpu_write(3'd2, 8'd0);
    check_status("err_kept_status", 8'h41);
    cpu_write(3'd5, 8'h00);
    wait_idle(50);
    check_status("err_cleared_status", 8'h01);
    exp_q.delete();

    // Reset in the middle of a fill.
    for (int i = 0; i < 4800; i++) exp_q.push_back({13'(i), 7'h02});
    cpu_write(3'd2, 8'd80);
    cpu_write(3'd4, 8'h02);
    n_acc = 0;
    cpu_write(3'd5, 8'h00);
    wait_acc(100, 300);
    @(negedge clk);
    #2;
    check("pre_rst_we", {31'd0, fb_if.FB_WE}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_we", {31'd0, fb_if.FB_WE}, 32'd0);
    check("mid_rst_addr", {19'd0, fb_if.FB_ADDR}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_status("post_rst_status", 8'h00);
    check("post_rst_state", {30'd0, dbg_state}, 32'd0);
    n_acc = 0;
    busy_cycles = 0;
    cpu_write(3'd5, 8'h00);
    wait_idle(50);
    check("post_rst_count", n_acc, 0);
    check("post_rst_busy", busy_cycles, 1);
    check_status("post_rst_done", 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
